ps2_kbd_tx: RTL and testbench

Device-side PS/2 keyboard transmitter: accepts 9-bit key events {break, scan}, buffers them, and serialises them onto ps2_clk/ps2_data as standard 11-bit device-to-host frames. For a break event it sends the 0xF0 prefix before the scan code. It is the sending end for the on-chip PS/2 receiver. It serves as a keyboard model for loopback tests and as a scripted key source on the board.

---
 rtl/ps2_pkg.sv | 30 +++
 rtl/ps2_kbd_tx_if.sv | 9 +
 rtl/ps2_evt_fifo.sv | 77 +++++++
 rtl/ps2_kbd_tx.sv | 189 ++++++++++++++++++
 tb/tb_ps2_kbd_tx.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: frame constants, key event type, transmitter FSM states
// and the frame/parity helpers.
package ps2_pkg;

  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
  localparam int         PS2_FRAME_BITS   = 11;

  typedef struct packed {
    logic       brk;
    logic [7:0] scan;
  } ps2_evt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    FRAME  = 2'd2,
    GAP    = 2'd3
  } ps2_state_e;

  // Parity bit that makes data plus parity hold an odd number of ones.
  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

  // Frame as shifted out LSB first: start, data[0..7], parity, stop.
  function automatic logic [10:0] frame_word(input logic [7:0] b);
    return {1'b1, odd_parity(b), b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_kbd_tx_if.sv
// Key event write port of the PS/2 keyboard transmitter.
interface ps2_kbd_tx_if;
  logic [8:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ps2_evt_fifo.sv
// Synchronous key event FIFO with push/pop, full/empty and occupancy count;
// refused pushes (full) and pops (empty) are ignored.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  ps2_evt_t                   push_data,
  input  logic                       pop,
  output ps2_evt_t                   pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  ps2_evt_t             mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 push_ok_s;
  logic                 pop_ok_s;

  assign full     = (cnt_q == CNT_W'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign count    = cnt_q;
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer and count update; pointers wrap naturally since DEPTH is a power of two.
  always_comb begin
    push_ok_s = push & ~full;
    pop_ok_s  = pop & ~empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1'b1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1'b1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter: buffers {break, scan} events and sends
// them as 11-bit frames, prefixing 0xF0 for key releases.
module ps2_kbd_tx
  import ps2_pkg::*;
#(
  parameter int CLK_DIV    = 50,
  parameter int GAP_BITS   = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  ps2_kbd_tx_if.slave  evt,
  output logic         overflow,
  output logic         busy,
  output logic         ps2_clk,
  output logic         ps2_data
);

  localparam int DIV_W   = $clog2(2 * CLK_DIV);
  localparam int GAP_CYC = 2 * GAP_BITS * CLK_DIV;
  localparam int GAP_W   = $clog2(GAP_CYC + 1);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [DIV_W-1:0] CLK_HI_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_LAST    = GAP_W'(GAP_CYC - 1);
  localparam logic [3:0]       BIT_LAST    = 4'(PS2_FRAME_BITS - 1);

  ps2_state_e        state_q, state_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [3:0]        bit_q, bit_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [10:0]       shift_q, shift_d;
  logic              pend_q, pend_d;
  logic [7:0]        pend_scan_q, pend_scan_d;
  logic              clk_q, clk_d;
  logic              data_q, data_d;
  logic              busy_q, busy_d;
  logic              ready_q, ready_d;
  logic              ovf_q, ovf_d;

  logic              push_s;
  logic              pop_s;
  ps2_evt_t          head_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [CNT_W-1:0]  fifo_cnt_s;
  logic [CNT_W-1:0]  cnt_nxt_s;

  assign push_s    = evt.valid & ready_q & ~fifo_full_s;
  assign evt.ready = ready_q;
  assign overflow  = ovf_q;
  assign busy      = busy_q;
  assign ps2_clk   = clk_q;
  assign ps2_data  = data_q;

  ps2_evt_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (ps2_evt_t'(evt.data)),
    .pop       (pop_s),
    .pop_data  (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_cnt_s)
  );

  // Frame sequencer: one bit period is 2*CLK_DIV cycles, clock high then low.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    shift_d     = shift_q;
    pend_d      = pend_q;
    pend_scan_d = pend_scan_q;
    clk_d       = clk_q;
    data_d      = data_q;
    pop_s       = 1'b0;
    case (state_q)
      IDLE: begin
        clk_d  = 1'b1;
        data_d = 1'b1;
        if (!fifo_empty_s) begin
          pop_s  = 1'b1;
          div_d  = '0;
          bit_d  = 4'd0;
          data_d = 1'b0;
          if (head_s.brk) begin
            state_d     = PREFIX;
            shift_d     = frame_word(PS2_BREAK_PREFIX);
            pend_d      = 1'b1;
            pend_scan_d = head_s.scan;
          end else begin
            state_d = FRAME;
            shift_d = frame_word(head_s.scan);
          end
        end else begin
          state_d = IDLE;
        end
      end
      PREFIX, FRAME: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          clk_d = 1'b1;
          if (bit_q == BIT_LAST) begin
            state_d = GAP;
            gap_d   = '0;
            data_d  = 1'b1;
          end else begin
            bit_d   = bit_q + 4'd1;
            shift_d = {1'b1, shift_q[10:1]};
            data_d  = shift_q[1];
          end
        end else begin
          div_d = div_q + DIV_W'(1'b1);
          clk_d = (div_q < CLK_HI_LAST);
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) begin
          // The pending scan code after 0xF0 starts straight away, skipping IDLE.
          if (pend_q) begin
            state_d = FRAME;
            pend_d  = 1'b0;
            shift_d = frame_word(pend_scan_q);
            div_d   = '0;
            bit_d   = 4'd0;
            clk_d   = 1'b1;
            data_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_W'(1'b1);
        end
      end
      default: begin
        state_d = IDLE;
        clk_d   = 1'b1;
        data_d  = 1'b1;
      end
    endcase
  end

  // Status flags track the FIFO occupancy that the coming edge will produce.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   cnt_nxt_s = fifo_cnt_s + CNT_W'(1'b1);
      2'b01:   cnt_nxt_s = fifo_cnt_s - CNT_W'(1'b1);
      default: cnt_nxt_s = fifo_cnt_s;
    endcase
    ready_d = (cnt_nxt_s != CNT_W'(FIFO_DEPTH));
    busy_d  = (state_d != IDLE) || (cnt_nxt_s != '0);
    ovf_d   = ovf_q | (evt.valid & ~ready_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= 4'd0;
      gap_q       <= '0;
      shift_q     <= '1;
      pend_q      <= 1'b0;
      pend_scan_q <= 8'h00;
      clk_q       <= 1'b1;
      data_q      <= 1'b1;
      busy_q      <= 1'b0;
      ready_q     <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      shift_q     <= shift_d;
      pend_q      <= pend_d;
      pend_scan_q <= pend_scan_d;
      clk_q       <= clk_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      ready_q     <= ready_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Directed bench for ps2_kbd_tx: a host-side monitor decodes frames on ps2_clk
// falling edges and the sequences below compare them with hand-derived values.
module tb_ps2_kbd_tx;

  localparam int CLK_DIV    = 4;
  localparam int GAP_BITS   = 2;
  localparam int FIFO_DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic overflow, busy, ps2_clk, ps2_data;

  ps2_kbd_tx_if bus ();

  ps2_kbd_tx #(
    .CLK_DIV    (CLK_DIV),
    .GAP_BITS   (GAP_BITS),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .evt      (bus),
    .overflow (overflow),
    .busy     (busy),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int fall_cnt = 0;

  logic [7:0] mon_byte  [$];
  logic       mon_start [$];
  logic       mon_par   [$];
  logic       mon_stop  [$];
  int         mon_t     [$];

  logic        m_prev = 1'b1;
  logic [10:0] m_sh   = 11'h000;
  int          m_nb   = 0;
  int          m_t0   = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Host model: sample data on each ps2_clk fall, away from the clk edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_nb = 0;
    end else if (m_prev && !ps2_clk) begin
      fall_cnt++;
      if (m_nb == 0) m_t0 = cyc;
      m_sh[m_nb] = ps2_data;
      m_nb++;
      if (m_nb == 11) begin
        mon_start.push_back(m_sh[0]);
        mon_byte.push_back(m_sh[8:1]);
        mon_par.push_back(m_sh[9]);
        mon_stop.push_back(m_sh[10]);
        mon_t.push_back(m_t0);
        m_nb = 0;
      end
    end
    m_prev = ps2_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [8:0] ev);
    bus.data  = ev;
    bus.valid = 1'b1;
    tick();
    bus.valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check_eq("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input string tag, input int idx, input logic [7:0] b, input logic par);
    if (idx < mon_byte.size()) begin
      check_eq({tag, "_start"}, 32'(mon_start[idx]), 32'd0);
      check_eq({tag, "_byte"},  32'(mon_byte[idx]),  32'(b));
      check_eq({tag, "_par"},   32'(mon_par[idx]),   32'(par));
      check_eq({tag, "_stop"},  32'(mon_stop[idx]),  32'd1);
    end else begin
      check_eq({tag, "_present"}, 32'(mon_byte.size()), 32'(idx + 1));
    end
  endtask

  int t_s;
  int b;
  int fc;

  initial begin
    bus.data  = 9'h000;
    bus.valid = 1'b0;

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    check_eq("rst_clk",  32'(ps2_clk),   32'd1);
    check_eq("rst_data", 32'(ps2_data),  32'd1);
    check_eq("rst_rdy",  32'(bus.ready), 32'd1);
    check_eq("rst_busy", 32'(busy),      32'd0);
    check_eq("rst_ovf",  32'(overflow),  32'd0);
    tick();

    // Make 0x1C: latency, clock phases, frame content, total length 88+16
    put(9'h01C);
    check_eq("mk_busy",      32'(busy),     32'd1);
    check_eq("mk_pre_start", 32'(ps2_data), 32'd1);
    tick();
    t_s = cyc;
    check_eq("mk_start_data", 32'(ps2_data), 32'd0);
    check_eq("mk_start_clk",  32'(ps2_clk),  32'd1);
    repeat (3) tick();
    check_eq("mk_clk_high", 32'(ps2_clk), 32'd1);
    tick();
    check_eq("mk_clk_fall", 32'(ps2_clk), 32'd0);
    wait_idle(300);
    check_eq("mk_len", 32'(cyc - t_s), 32'd104);
    check_eq("mk_nframes", 32'(mon_byte.size()), 32'd1);
    check_frame("mk", 0, 8'h1C, 1'b0);
    repeat (5) tick();

    // Break 0x1C: F0 then 1C, gap of GAP_BITS periods between them
    b = mon_byte.size();
    put(9'h11C);
    tick();
    t_s = cyc;
    wait_idle(400);
    check_eq("brk_len", 32'(cyc - t_s), 32'd208);
    check_eq("brk_nframes", 32'(mon_byte.size()), 32'(b + 2));
    check_frame("brk_f0", b, 8'hF0, 1'b1);
    check_frame("brk_sc", b + 1, 8'h1C, 1'b0);
    if (mon_t.size() >= b + 2) check_eq("brk_spacing", 32'(mon_t[b+1] - mon_t[b]), 32'd104);
    repeat (5) tick();

    // Write during the gap after F0: pending 1C first, then 5A via IDLE
    b = mon_byte.size();
    put(9'h11C);
    tick();
    repeat (90) tick();
    put(9'h05A);
    wait_idle(600);
    check_eq("gw_nframes", 32'(mon_byte.size()), 32'(b + 3));
    check_frame("gw_f0", b, 8'hF0, 1'b1);
    check_frame("gw_sc", b + 1, 8'h1C, 1'b0);
    check_frame("gw_new", b + 2, 8'h5A, 1'b1);
    if (mon_t.size() >= b + 3) begin
      check_eq("gw_gap_pend", 32'(mon_t[b+1] - mon_t[b]),   32'd104);
      check_eq("gw_gap_next", 32'(mon_t[b+2] - mon_t[b+1]), 32'd105);
    end
    repeat (5) tick();

    // Overflow: valid held 10 cycles from idle -> 9 accepted, 10th dropped
    b = mon_byte.size();
    for (int i = 0; i < 10; i++) begin
      bus.data  = {1'b0, 8'(32'd33 + i)};
      bus.valid = 1'b1;
      tick();
      if (i == 7) begin
        check_eq("ov_rdy7", 32'(bus.ready), 32'd1);
        check_eq("ov_ovf7", 32'(overflow),  32'd0);
      end
      if (i == 8) check_eq("ov_rdy8", 32'(bus.ready), 32'd0);
    end
    bus.valid = 1'b0;
    check_eq("ov_ovf", 32'(overflow), 32'd1);
    wait_idle(2000);
    check_eq("ov_nframes", 32'(mon_byte.size()), 32'(b + 9));
    for (int k = 0; k < 9; k++) begin
      if (b + k < mon_byte.size()) check_eq("ov_order", 32'(mon_byte[b+k]), 32'd33 + 32'(k));
    end
    check_eq("ov_sticky", 32'(overflow),  32'd1);
    check_eq("ov_rdy_end", 32'(bus.ready), 32'd1);
    repeat (5) tick();

    // Reset during bit 5: lines high, flags cleared, nothing more sent
    b = mon_byte.size();
    put(9'h033);
    tick();
    repeat (42) tick();
    check_eq("mr_mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    fc = fall_cnt;
    check_eq("mr_clk",  32'(ps2_clk),   32'd1);
    check_eq("mr_data", 32'(ps2_data),  32'd1);
    check_eq("mr_busy", 32'(busy),      32'd0);
    check_eq("mr_rdy",  32'(bus.ready), 32'd1);
    check_eq("mr_ovf",  32'(overflow),  32'd0);
    repeat (300) tick();
    check_eq("mr_no_falls",  32'(fall_cnt),        32'(fc));
    check_eq("mr_no_frames", 32'(mon_byte.size()), 32'(b));
    check_eq("mr_idle_busy", 32'(busy),            32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
